// File: rtl/ws2812_frame_scheduler_if.sv
// Pixel RAM read port and pixel stream toward the WS2812 bit transmitter.
interface ws2812_frame_scheduler_if #(
  parameter int unsigned ADDR_W = 6
);
  localparam int unsigned PX_W = 24;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PX_W-1:0]   rd_data;
  logic              px_valid;
  logic [PX_W-1:0]   px_data;
  logic              px_ready;
  logic              tx_idle;

  modport master (
    output rd_en, rd_addr, px_valid, px_data,
    input  rd_data, px_ready, tx_idle
  );

  modport slave (
    input  rd_en, rd_addr, px_valid, px_data,
    output rd_data, px_ready, tx_idle
  );
endinterface

// File: rtl/ws2812_frame_scheduler.sv
// Walks the pixel RAM once per frame, offers each GRB word to the bit
// transmitter, then holds the latch gap before finishing or auto-restarting.
module ws2812_frame_scheduler #(
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned RESET_CYCLES = 15000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W:0]         led_count,
  input  logic                    auto_en,
  input  logic                    abort,
  ws2812_frame_scheduler_if.master bus,
  output logic                    busy,
  output logic                    frame_done
);
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned PX_W  = 24;
  localparam int unsigned GAP_W = $clog2(RESET_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_PRESENT, S_LATCH
  } state_e;

  state_e            state_q, state_nxt;
  logic [CNT_W-1:0]  idx_q, idx_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [GAP_W-1:0]  gap_q, gap_nxt;
  logic              aborted_q, aborted_nxt;
  logic              done_nxt;

  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              px_valid_q, px_valid_d;
  logic [PX_W-1:0]   px_data_q, px_data_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      aborted_q    <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      px_valid_q   <= 1'b0;
      px_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      idx_q        <= idx_nxt;
      cnt_q        <= cnt_nxt;
      gap_q        <= gap_nxt;
      aborted_q    <= aborted_nxt;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      px_valid_q   <= px_valid_d;
      px_data_q    <= px_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state: abort outranks start and the pixel handshake
  always_comb begin
    state_nxt   = state_q;
    idx_nxt     = idx_q;
    cnt_nxt     = cnt_q;
    gap_nxt     = '0;
    aborted_nxt = aborted_q;
    done_nxt    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort && (led_count != '0)) begin
          cnt_nxt     = led_count;
          idx_nxt     = '0;
          aborted_nxt = 1'b0;
          state_nxt   = S_FETCH;
        end
      end
      S_FETCH, S_WAIT: begin
        if (abort) begin
          aborted_nxt = 1'b1;
          state_nxt   = S_LATCH;
        end else begin
          state_nxt = (state_q == S_FETCH) ? S_WAIT : S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (abort) begin
          aborted_nxt = 1'b1;
          state_nxt   = S_LATCH;
        end else if (bus.px_ready) begin
          if (idx_q != cnt_q - CNT_W'(1)) begin
            idx_nxt   = idx_q + CNT_W'(1);
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_LATCH;
          end
        end
      end
      S_LATCH: begin
        aborted_nxt = aborted_q | abort;
        if (!bus.tx_idle) begin
          gap_nxt = '0;
        end else if (gap_q == GAP_LAST) begin
          done_nxt    = !aborted_nxt;
          aborted_nxt = 1'b0;
          if (done_nxt && auto_en) begin
            idx_nxt   = '0;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          gap_nxt = gap_q + GAP_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it
  always_comb begin
    rd_en_d      = (state_nxt == S_FETCH);
    rd_addr_d    = rd_en_d ? idx_nxt[ADDR_W-1:0] : '0;
    px_valid_d   = (state_nxt == S_PRESENT);
    busy_d       = (state_nxt != S_IDLE);
    frame_done_d = done_nxt;
    px_data_d    = (state_q == S_WAIT) ? bus.rd_data : px_data_q;
  end

  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.px_valid = px_valid_q;
  assign bus.px_data  = px_data_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
endmodule

// File: doc/ws2812_frame_scheduler.md
WS2812_FRAME_SCHEDULER -- requirements
Module: ws2812_frame_scheduler

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 6, meaning pixel RAM address width (max 2^ADDR_W LEDs).
REQ-002 The module SHALL have parameter RESET_CYCLES, default 15000, meaning the latch gap in clk cycles (300 us at 50 MHz).
REQ-003 The module SHALL have port clk, input, 1, meaning system clock; all logic on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-005 The module SHALL have port start, input, 1, meaning a one-cycle frame request.
REQ-006 The module SHALL have port led_count, input, ADDR_W+1, meaning the number of LEDs in the frame, sampled on accepted start.
REQ-007 The module SHALL have port auto_en, input, 1, meaning continuous refresh: restart the frame after each gap.
REQ-008 The module SHALL have port abort, input, 1, meaning terminate the current frame.
REQ-009 The module SHALL have port rd_en, output, 1, meaning the pixel RAM read strobe.
REQ-010 The module SHALL have port rd_addr, output, ADDR_W, meaning the pixel RAM read address.
REQ-011 The module SHALL have port rd_data, input, 24, meaning GRB pixel data, valid exactly 1 cycle after rd_en.
REQ-012 The module SHALL have port px_valid, output, 1, meaning a pixel word is offered to the bit transmitter.
REQ-013 The module SHALL have port px_data, output, 24, meaning the offered pixel word.
REQ-014 The module SHALL have port px_ready, input, 1, meaning the transmitter accepts px_data this cycle.
REQ-015 The module SHALL have port tx_idle, input, 1, meaning the transmitter has finished shifting all bits.
REQ-016 The module SHALL have port busy, output, 1, meaning high in every state except IDLE.
REQ-017 The module SHALL have port frame_done, output, 1, meaning a one-cycle pulse at normal frame completion.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, WAIT, PRESENT and LATCH, with a pixel index idx (ADDR_W+1 bits) and a latched count cnt.
REQ-019 IDLE: start=1 with led_count!=0 and abort=0 SHALL latch cnt=led_count, set idx=0 and go to FETCH next cycle.
REQ-020 IDLE: start with led_count=0 SHALL be ignored (busy stays 0 and no pulse occurs).
REQ-021 FETCH SHALL last 1 cycle, with rd_en=1 and rd_addr=idx[ADDR_W-1:0], and then go to WAIT.
REQ-022 WAIT SHALL last 1 cycle and capture rd_data into px_data; the next state is PRESENT.
REQ-023 PRESENT SHALL hold px_valid=1, with px_data stable, until px_ready=1.
REQ-024 On handshake in PRESENT, the FSM SHALL set px_valid=0 next cycle, then go to FETCH with idx+1 if idx<cnt-1, else to LATCH.
REQ-025 rd_en SHALL be 0 outside FETCH, and px_valid SHALL be 0 outside PRESENT.
REQ-026 LATCH: the gap counter SHALL be held at 0 while tx_idle=0, and SHALL increment each cycle while tx_idle=1.
REQ-027 LATCH: a tx_idle drop mid-gap SHALL clear the gap counter to 0.
REQ-028 LATCH SHALL exit when the gap counter reaches RESET_CYCLES-1 with tx_idle=1.
REQ-029 On LATCH exit of a normal frame, frame_done SHALL be 1 for that one cycle.
REQ-030 On LATCH exit, the next state SHALL be FETCH with idx=0 and cnt unchanged if auto_en=1 in that cycle, else IDLE.
REQ-031 start SHALL be ignored while busy=1.
REQ-032 In FETCH, WAIT or PRESENT, abort=1 SHALL force LATCH next cycle, drop px_valid with no handshake, and mark the frame aborted.
REQ-033 An aborted frame SHALL not pulse frame_done, and SHALL return to IDLE regardless of auto_en.
REQ-034 abort in LATCH SHALL mark the frame aborted without restarting the gap.
REQ-035 abort in IDLE SHALL have no effect, and abort SHALL win over a simultaneous start.
REQ-036 px_ready outside PRESENT SHALL be ignored.
REQ-037 A frame of N LEDs SHALL issue exactly N reads, at addresses 0..N-1 in order.
REQ-038 The minimum per-pixel period SHALL be 3 cycles (FETCH, WAIT, PRESENT with px_ready already high).

Reset
REQ-039 While rst_n=0, the module SHALL hold state=IDLE, idx=0, cnt=0, gap counter=0, the aborted flag=0 and px_data=0.
REQ-040 While rst_n=0, every output SHALL be 0: rd_en, rd_addr, px_valid, busy and frame_done.
REQ-041 Reset asserted mid-frame SHALL immediately drop px_valid and rd_en, and SHALL not generate frame_done.
REQ-042 After rst_n rises, the module SHALL stay in IDLE until a valid start.

Verification
REQ-043 The bench SHALL cover: RESET_CYCLES=8, start with led_count=3, px_ready=1, tx_idle=1 -> reads at addresses 0,1,2, px_valid every 3 cycles, then 8 gap cycles, then one frame_done pulse, then busy=0.
REQ-044 The bench SHALL cover: px_ready held low 5 cycles on pixel 1 -> px_valid=1 and px_data unchanged throughout, with no rd_en until the handshake.
REQ-045 The bench SHALL cover: tx_idle=0 for 4 cycles after the last handshake, then 1, with a 1-cycle drop mid-gap -> the gap restarts and frame_done is delayed accordingly.
REQ-046 The bench SHALL cover: auto_en=1, led_count=2 -> frames repeat with reads 0,1,0,1,..., a frame_done per frame, and busy staying 1.
REQ-047 The bench SHALL cover: abort during PRESENT of pixel 1 of 4 -> px_valid=0 next cycle, then a gap, then IDLE, with no frame_done.
REQ-048 The bench SHALL cover: start with led_count=0, start while busy, and start+abort in IDLE -> all ignored.
